mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single interleaved DRAM request/response port, upstream of the DRAM interleaver, between two masters.
- Requester 0 is the PCIe-to-DRAM streamer; requester 1 is the Hast IP wrapper's memory engine.
- Arbitrates requests round-robin and records the issuer of every read in an in-order tag FIFO.
- Routes each read response back to the requester that issued it.

Parameters:
- TAG_LOG_DEPTH, 6, log2 of the maximum number of outstanding reads (64).
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_in[1:0]  in  MemReq (578b each)  per-requester request {valid, isWrite, addr[63:0], data[511:0]}.
- req_grant_out[1:0]  out  1 each  request accepted this cycle.
- resp_out[1:0]  out  MemResp (513b each)  routed read response {valid, data[511:0]}.
- resp_grant_in[1:0]  in  1 each  requester consumes its response.
- mem_req_out  out  MemReq  to interleaver.
- mem_req_grant_in  in  1  interleaver accepts mem_req_out.
- mem_resp_in  in  MemResp  from interleaver.
- mem_resp_grant_out  out  1  consume mem_resp_in.
- tag_full_out  out  1  debug: tag FIFO full.
- grant_cnt_out[1:0]  out  CNT_W each  accepted-request counters (macro only; tied 0 otherwise).

Behaviour:
- Memory handshake: same-cycle valid/grant; a transfer happens when valid && grant in the same cycle. Only reads return responses; they return in issue order.
- Request path (combinational from inputs and registered state):
  - Eligible(i) = req_in[i].valid && (req_in[i].isWrite || !tag_full).
  - Both eligible: winner = requester not equal to last_winner. One eligible: that one. None: mem_req_out.valid=0 and all other fields 0.
  - mem_req_out = req_in[winner] unchanged.
  - req_grant_out[winner] = mem_req_grant_in; the loser's grant is 0.
  - A request must be held stable by its requester until granted.
- last_winner register updates to winner only on an accepted transfer (valid && grant). Reset value 1, so requester 0 wins the first contention.
- Tag FIFO:
  - Width 1 (requester id), depth 2^TAG_LOG_DEPTH.
  - Push the winner id on every accepted read; writes never push.
  - tag_full is derived from the registered count. When the FIFO is full, a read is not eligible even if a pop happens in the same cycle. Writes still proceed when full.
- Response path:
  - Tag FIFO non-empty, head = h: resp_out[h] = mem_resp_in; resp_out[!h].valid = 0; mem_resp_grant_out = resp_grant_in[h]. Pop the tag when mem_resp_in.valid && resp_grant_in[h].
  - Tag FIFO empty: both resp_out.valid = 0 and mem_resp_grant_out = 0. A response arriving in this state is a protocol error and triggers a simulation assertion.
  - Simultaneous push and pop: count unchanged; both take effect.
- Latency: zero added cycles on both the request and response paths (purely combinational steering).
- Reset:
  - All grants 0, mem_req_out.valid 0, resp_out valid 0, mem_resp_grant_out 0, tag FIFO emptied, last_winner = 1, counters 0.
  - Reset mid-operation drops all outstanding tags. The owner must reset the interleaver and DRAM path in the same cycle.
- Data fields of resp_out[!h] are driven 0.

Optional Feature:
- MEM_ARB_PERF_CNT_EN
  - Defined: grant_cnt_out[i] increments by 1 on each accepted request from requester i, saturating at all-ones. Counters are cleared by rst.
  - Undefined: grant_cnt_out is tied to 0 and no counter flops exist.

Decomposition:
- MemReq and MemResp come from ShellTypes.
- New package mem_arb_pkg holds:
  - typedef ArbReqId (1-bit requester id);
  - constants REQ_STREAMER=0 and REQ_HAST=1;
  - the reset value of last_winner.
- One sub-module: arb_tag_fifo. It is a synchronous 1-bit FIFO exposing push, pop, head, full, empty and count, and is instantiated once.

Test Plan:
- Requester 0 only: 4 reads to addr 0x0, 0x10, 0x20, 0x30 with grant held high -> 4 back-to-back grants; responses D0..D3 appear only on resp_out[0]; tag FIFO returns to empty.
- Both requesters issue continuous reads, grant always high -> grants alternate 0,1,0,1 starting with 0; responses are routed in that same alternating order.
- Requester 1 issues 64 reads with responses held off -> tag_full_out=1 after the 64th grant. A 65th read is not granted, while a requester 0 write to 0x100 is granted. After one response pop, the 65th read is granted.
- Interleaved write then read from requester 1, with a requester 0 read outstanding -> the write does not push a tag; responses go to 0 then 1.
- resp_grant_in[0]=0 for 5 cycles while the head tag is 0 -> mem_resp_grant_out=0 for those cycles; response data is held; no pop occurs.
- Assert rst with 10 reads outstanding -> the next cycle has tags empty, all valids 0, and last_winner=1. With MEM_ARB_PERF_CNT_EN defined, counters read 0.

Source files
------------

// File: rtl/ShellTypes.sv
// Shell-wide memory port types shared by the DRAM request/response path.
// MemReq is {valid, isWrite, addr, data}; MemResp is {valid, data}.
package ShellTypes;

    typedef struct packed {
        logic         valid;
        logic         isWrite;
        logic [63:0]  addr;
        logic [511:0] data;
    } MemReq;

    typedef struct packed {
        logic         valid;
        logic [511:0] data;
    } MemResp;

endpackage

// File: rtl/mem_arb_pkg.sv
// Requester identifiers and reset constants for the two-master DRAM port arbiter.
package mem_arb_pkg;

    typedef logic ArbReqId;

    localparam ArbReqId REQ_STREAMER = 1'b0;
    localparam ArbReqId REQ_HAST     = 1'b1;

    // Resetting to the Hast side hands the first contention to the streamer.
    localparam ArbReqId LAST_WINNER_RST = REQ_HAST;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of 1-bit requester ids, one entry per outstanding read.
// Pushes when full and pops when empty are prevented by the caller.
module arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int LOG_DEPTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  ArbReqId            push_id,
    input  logic               pop,
    output ArbReqId            head,
    output logic               full,
    output logic               empty,
    output logic [LOG_DEPTH:0] count
);

    localparam logic [LOG_DEPTH:0] FULL_CNT = {1'b1, {LOG_DEPTH{1'b0}}};

    logic [(1<<LOG_DEPTH)-1:0] tags;
    logic [LOG_DEPTH-1:0]      wr_ptr;
    logic [LOG_DEPTH-1:0]      rd_ptr;

    // Tag storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) tags[wr_ptr] <= push_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = tags[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one DRAM request/response port between the PCIe streamer (0)
// and the Hast engine (1). Define MEM_ARB_PERF_CNT_EN for per-requester grant counters.
module mem_port_arbiter
    import ShellTypes::*;
    import mem_arb_pkg::*;
#(
    parameter int TAG_LOG_DEPTH = 6,
    parameter int CNT_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  MemReq  [1:0]          req_in,
    output logic   [1:0]          req_grant_out,
    output MemResp [1:0]          resp_out,
    input  logic   [1:0]          resp_grant_in,
    output MemReq                 mem_req_out,
    input  logic                  mem_req_grant_in,
    input  MemResp                mem_resp_in,
    output logic                  mem_resp_grant_out,
    output logic                  tag_full_out,
    output logic [1:0][CNT_W-1:0] grant_cnt_out
);

    ArbReqId                last_winner;
    ArbReqId                winner;
    logic [1:0]             eligible;
    logic                   any_eligible;
    logic                   accept;
    logic                   tag_push;
    logic                   tag_pop;
    ArbReqId                tag_head;
    logic                   tag_full;
    logic                   tag_empty;
    logic [TAG_LOG_DEPTH:0] tag_count;

    // A full tag FIFO blocks reads only; writes never need a return slot.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            eligible[i] = req_in[i].valid && (req_in[i].isWrite || !tag_full);
        end
    end

    always_comb begin
        winner = last_winner;
        if (eligible == 2'b11)  winner = ~last_winner;
        else if (eligible[0])   winner = REQ_STREAMER;
        else if (eligible[1])   winner = REQ_HAST;
    end

    assign any_eligible = |eligible;
    assign accept       = any_eligible && mem_req_grant_in;
    assign tag_push     = accept && !req_in[winner].isWrite;
    assign mem_req_out  = any_eligible ? req_in[winner] : '0;

    always_comb begin
        req_grant_out = '0;
        if (any_eligible) req_grant_out[winner] = mem_req_grant_in;
    end

    always_ff @(posedge clk) begin
        if (rst)         last_winner <= LAST_WINNER_RST;
        else if (accept) last_winner <= winner;
    end

    arb_tag_fifo #(
        .LOG_DEPTH(TAG_LOG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tag_push),
        .push_id (winner),
        .pop     (tag_pop),
        .head    (tag_head),
        .full    (tag_full),
        .empty   (tag_empty),
        .count   (tag_count)
    );

    // Responses return in issue order, so the FIFO head names their owner.
    always_comb begin
        resp_out           = '0;
        mem_resp_grant_out = 1'b0;
        if (!tag_empty) begin
            resp_out[tag_head] = mem_resp_in;
            mem_resp_grant_out = resp_grant_in[tag_head];
        end
    end

    assign tag_pop      = !tag_empty && mem_resp_in.valid && resp_grant_in[tag_head];
    assign tag_full_out = tag_full;

    resp_without_tag: assert property (@(posedge clk) disable iff (rst)
        !(mem_resp_in.valid && tag_count == '0));

`ifdef MEM_ARB_PERF_CNT_EN
    logic [1:0][CNT_W-1:0] grant_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req_grant_out[i] && grant_cnt[i] != '1) grant_cnt[i] <= grant_cnt[i] + 1'b1;
            end
        end
    end

    assign grant_cnt_out = grant_cnt;
`else
    assign grant_cnt_out = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: queue-level reference model plus a
// per-requester response scoreboard.
module tb_mem_port_arbiter;
  import ShellTypes::*;

  localparam int DEPTH = 64;
  localparam int CNT_W = 32;

  logic                  clk;
  logic                  rst;
  MemReq  [1:0]          req_in;
  logic   [1:0]          req_grant_out;
  MemResp [1:0]          resp_out;
  logic   [1:0]          resp_grant_in;
  MemReq                 mem_req_out;
  logic                  mem_req_grant_in;
  MemResp                mem_resp_in;
  logic                  mem_resp_grant_out;
  logic                  tag_full_out;
  logic [1:0][CNT_W-1:0] grant_cnt_out;

  mem_port_arbiter #(.TAG_LOG_DEPTH(6), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_in             (req_in),
    .req_grant_out      (req_grant_out),
    .resp_out           (resp_out),
    .resp_grant_in      (resp_grant_in),
    .mem_req_out        (mem_req_out),
    .mem_req_grant_in   (mem_req_grant_in),
    .mem_resp_in        (mem_resp_in),
    .mem_resp_grant_out (mem_resp_grant_out),
    .tag_full_out       (tag_full_out),
    .grant_cnt_out      (grant_cnt_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  int checks = 0;
  int errors = 0;

  logic [511:0] exp_q0[$];
  logic [511:0] exp_q1[$];
  bit           own_q[$];
  logic [511:0] dat_q[$];

  bit               pend[2];
  bit               acc[2];
  MemReq            preq[2];
  int               last_w;
  logic [CNT_W-1:0] cnt[2];

  int p_req[2], p_wr[2], p_rg[2];
  int p_mg, p_rsp;

  typedef struct {
    int cyc;
    int rq0, rq1, wr0, wr1, mg, rsp, rg0, rg1;
    bit rst_after;
  } phase_t;

  phase_t ph[10];

  function automatic bit chance(int p);
    return int'($urandom_range(99)) < p;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] resp_data(logic [63:0] addr);
    return {8{addr}} ^ {16{32'h5A3C_96E1}};
  endfunction

  task automatic chk(string name, logic [639:0] act, logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    own_q.delete();
    dat_q.delete();
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0;
      acc[i]  = 0;
      cnt[i]  = '0;
    end
    last_w = 1;
  endtask

  task automatic drive_idle();
    req_in           = '0;
    resp_grant_in    = '0;
    mem_req_grant_in = 1'b0;
    mem_resp_in      = '0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle();
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        pend[i] = 0;
        acc[i]  = 0;
      end
      if (!pend[i] && chance(p_req[i])) begin
        preq[i].valid   = 1'b1;
        preq[i].isWrite = chance(p_wr[i]);
        preq[i].addr    = {$urandom, $urandom};
        preq[i].data    = rand512();
        pend[i]         = 1;
      end
      req_in[i]        = pend[i] ? preq[i] : '0;
      resp_grant_in[i] = chance(p_rg[i]);
    end
    mem_req_grant_in = chance(p_mg);
    if (own_q.size() > 0 && chance(p_rsp)) mem_resp_in = {1'b1, dat_q[0]};
    else                                   mem_resp_in = {1'b0, rand512()};
  endtask

  // ---------------- request-side model and routing checks ----------------
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      int           n;
      bit           full;
      bit           el[2];
      bit           any;
      int           w;
      int           h;
      MemReq        exp_req;
      logic [1:0]   exp_grant;
      logic [511:0] d;

      n    = own_q.size();
      full = (n >= DEPTH);
      for (int i = 0; i < 2; i++) el[i] = pend[i] && (preq[i].isWrite || !full);
      any = el[0] || el[1];
      if (el[0] && el[1]) w = 1 - last_w;
      else                w = el[0] ? 0 : 1;
      exp_req   = any ? preq[w] : '0;
      exp_grant = '0;
      if (any && mem_req_grant_in) exp_grant[w] = 1'b1;

      chk("mem_req_out", 640'(mem_req_out), 640'(exp_req));
      chk("req_grant_out", 640'(req_grant_out), 640'(exp_grant));
      chk("tag_full_out", 640'(tag_full_out), 640'(full));
`ifdef MEM_ARB_PERF_CNT_EN
      chk("grant_cnt0", 640'(grant_cnt_out[0]), 640'(cnt[0]));
      chk("grant_cnt1", 640'(grant_cnt_out[1]), 640'(cnt[1]));
`else
      chk("grant_cnt_tied", 640'(grant_cnt_out), 640'(0));
`endif

      if (n > 0) begin
        h = own_q[0] ? 1 : 0;
        chk("resp_out_head", 640'(resp_out[h]), 640'(mem_resp_in));
        chk("resp_out_other", 640'(resp_out[1-h]), 640'(0));
        chk("mem_resp_grant", 640'(mem_resp_grant_out), 640'(resp_grant_in[h]));
        if (mem_resp_in.valid && resp_grant_in[h]) begin
          void'(own_q.pop_front());
          void'(dat_q.pop_front());
        end
      end else begin
        chk("resp_valid_idle", 640'({resp_out[1].valid, resp_out[0].valid}), 640'(0));
        chk("mem_resp_grant_idle", 640'(mem_resp_grant_out), 640'(0));
      end

      if (any && mem_req_grant_in) begin
        acc[w] = 1;
        last_w = w;
        if (cnt[w] != '1) cnt[w] = cnt[w] + 1'b1;
        if (!preq[w].isWrite) begin
          d = resp_data(preq[w].addr);
          own_q.push_back(w == 1);
          dat_q.push_back(d);
          if (w == 0) exp_q0.push_back(d);
          else        exp_q1.push_back(d);
        end
      end
    end
  end

  // ---------------- response scoreboard ----------------
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      if (resp_out[0].valid && resp_grant_in[0]) begin
        if (exp_q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp0_unexpected: got %0h expected none", resp_out[0].data);
        end else begin
          chk("resp0_data", 640'(resp_out[0].data), 640'(exp_q0.pop_front()));
        end
      end
      if (resp_out[1].valid && resp_grant_in[1]) begin
        if (exp_q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp1_unexpected: got %0h expected none", resp_out[1].data);
        end else begin
          chk("resp1_data", 640'(resp_out[1].data), 640'(exp_q1.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus sequence and report ----------------
  initial begin
    int drain;

    ph[0] = '{20,  100, 0,   0,   0,   100, 100, 100, 100, 0};
    ph[1] = '{30,  100, 100, 0,   0,   100, 100, 100, 100, 0};
    ph[2] = '{80,  0,   100, 0,   0,   100, 0,   100, 100, 0};
    ph[3] = '{20,  100, 100, 100, 0,   100, 0,   100, 100, 0};
    ph[4] = '{40,  0,   100, 0,   0,   100, 100, 100, 100, 0};
    ph[5] = '{30,  100, 100, 50,  50,  100, 100, 0,   100, 0};
    ph[6] = '{300, 60,  60,  30,  30,  70,  60,  70,  70,  0};
    ph[7] = '{15,  100, 100, 0,   0,   100, 0,   100, 100, 1};
    ph[8] = '{20,  100, 100, 0,   0,   100, 100, 100, 100, 0};
    ph[9] = '{400, 50,  80,  40,  20,  60,  70,  60,  80,  0};

    rst = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);

    for (int p = 0; p < 10; p++) begin
      p_req[0] = ph[p].rq0;  p_req[1] = ph[p].rq1;
      p_wr[0]  = ph[p].wr0;  p_wr[1]  = ph[p].wr1;
      p_rg[0]  = ph[p].rg0;  p_rg[1]  = ph[p].rg1;
      p_mg     = ph[p].mg;   p_rsp    = ph[p].rsp;
      for (int c = 0; c < ph[p].cyc; c++) begin
        @(negedge clk);
        rst = 1'b0;
        drive_cycle();
      end
      if (ph[p].rst_after) begin
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        model_reset();
      end
    end

    p_req[0] = 0;   p_req[1] = 0;
    p_rg[0]  = 100; p_rg[1]  = 100;
    p_mg     = 100; p_rsp    = 100;
    drain = 0;
    while ((own_q.size() > 0 || pend[0] || pend[1] || acc[0] || acc[1]) && drain < 500) begin
      @(negedge clk);
      drive_cycle();
      drain++;
    end
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);

    chk("drain_timeout", 640'(drain >= 500), 640'(0));
    chk("exp_q0_empty", 640'(exp_q0.size()), 640'(0));
    chk("exp_q1_empty", 640'(exp_q1.size()), 640'(0));
    chk("tag_full_final", 640'(tag_full_out), 640'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
